reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer of the Tomasulo RISC-V core. It sits between the dispatcher (allocation), the CDB (writeback) and the register file (commit). It retires instructions in program order, one per cycle. It produces the commit flag with rd/V/Q and the rollback flag that the register file consumes to free or clear rename tags.

## Interface
- `ROB_TAG_W`, default 4: tag width. Valid tags are 1..2^W-1 (15 slots). Tag 0 = `ROB_RESET` = "no producer".
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global ready; low freezes state.
- `alloc_valid_in`  in  1  dispatcher allocates the slot at `alloc_tag_out`.
- `alloc_rd_in`  in  `REG_TYPE`  destination register (`REG_RESET` = none).
- `alloc_kind_in`  in  2  0 normal, 1 branch, 2 store.
- `alloc_tag_out`  out  `ROB_TYPE`  tag of the tail slot.
- `full_out`  out  1  count == 15.
- `q1_tag_in`, `q2_tag_in`  in  `ROB_TYPE`  operand producer tags.
- `q1_ready_out`, `q2_ready_out`  out  1  producer value available.
- `q1_value_out`, `q2_value_out`  out  `DATA_TYPE`  that value.
- `wb_valid_in`  in  1  CDB broadcast.
- `wb_tag_in`  in  `ROB_TYPE`  CDB tag.
- `wb_value_in`  in  `DATA_TYPE`  CDB result.
- `wb_mispredict_in`  in  1  branch outcome differs from prediction.
- `wb_target_in`  in  32  correct PC for a mispredict.
- `commit_flag_out`  out  1  one-cycle commit pulse.
- `commit_rd_out`  out  `REG_TYPE`  committed rd.
- `commit_value_out`  out  `DATA_TYPE`  committed V.
- `commit_tag_out`  out  `ROB_TYPE`  committed Q.
- `store_commit_out`  out  1  head store retired (to LSB).
- `rollback_flag_out`  out  1  one-cycle flush pulse.
- `rollback_pc_out`  out  32  redirect PC.

## Operation
- State:
  - per-slot busy, ready, rd, kind, value, mispredict, target;
  - head, tail, count.
  - Reset: head = tail = 1, count = 0, all busy/ready = 0.
- Tag increment wraps 15 → 1, never 0.
- **Allocate:** `alloc_valid_in` && !full writes the tail slot (busy = 1, ready = 0) and advances tail. Allocation while full is ignored.
- **Writeback:** `wb_valid_in` to a busy slot sets ready and stores value, mispredict and target. Writeback to a non-busy slot or to tag 0 is ignored.
- **Commit:** if the head slot is busy and ready, the slot is retired at the edge and head advances.
  - Registered outputs: commit_flag = 1, rd, value, tag = head tag.
  - store_commit = 1 if kind = store.
  - Branches with rd = none still pulse commit_flag with rd = `REG_RESET`.
- **Mispredict commit:** commit outputs as above, plus rollback_flag = 1 and rollback_pc = target. At the same edge all slots are cleared, head = tail = 1, count = 0. Same-edge allocate and writeback are dropped.
- **In the cycle `rollback_flag_out` is high:** alloc and wb inputs are ignored, because they belong to flushed work.
- **count:**
  - alloc and commit together: count unchanged;
  - alloc only: +1;
  - commit only: −1.
- **Query:** combinational.
  - ready = slot busy && ready, or (`wb_valid_in` && `wb_tag_in` == q_tag), with the wb value forwarded.
  - q_tag 0: ready = 1, value = 0.
- **`rdy_in` low:** all state held; pulse outputs forced to 0 at the next edge.

## Timing
- All outputs reset to 0, except `alloc_tag_out` = 1.
- `alloc_tag_out` and `full_out` are combinational from tail/count.
- Writeback latency: wb at edge E sets ready; commit at edge E+1; `commit_flag_out` is high in the cycle after E+1.
- Commit throughput: at most one instruction per cycle.
- Pulses last exactly one cycle unless another commit follows back-to-back.
- Wb to the head slot and commit in the same cycle: commit uses the pre-edge ready only.

## Structure
- `constants.v` holds:
  - `ROB_TYPE`, `ROB_RESET`, `REG_TYPE`, `REG_RESET`, `DATA_TYPE`, `DATA_RESET`;
  - kind encodings `ROB_KIND_NORMAL/BRANCH/STORE`;
  - `ROB_SIZE`.
- One sub-module, `rob_query_port`: tag lookup plus CDB bypass, instantiated twice.

## Test plan
- **Reset:** assert `rst_in` with no clock edge → all outputs 0, `alloc_tag_out` = 1, `full_out` = 0 immediately.
- **Basic commit:** alloc rd = 5 (tag 1), then wb tag 1 value 0x1234 → commit_flag = 1, rd = 5, value = 0x1234, tag = 1, appearing two edges after the wb edge.
- **Out-of-order writeback:** alloc tags 1, 2, 3; wb order 3, 2, 1 → commits tag 1, 2, 3 on consecutive cycles.
- **Full and wrap-around:** alloc 15 → `full_out` = 1 and a 16th alloc is ignored; commit tag 1, then alloc → tag 1 reused; tail wraps 15 → 1.
- **Mispredict flush:** alloc tags 1–4, tag 2 a branch; wb tag 2 with mispredict and target 0x100; then wb 1 →
  - commit tag 1, then rollback_flag = 1 with pc = 0x100;
  - afterwards count = 0 and `alloc_tag_out` = 1;
  - a later wb to tag 3 is ignored.
- **Query bypass:** q1_tag = 2 with a same-cycle wb of tag 2 value 0xBEEF → q1_ready = 1, q1_value = 0xBEEF combinationally; q2_tag = 0 → ready = 1, value = 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer.
// Tag 0 is reserved as "no producer", so a W-bit tag space holds 2^W-1 slots.
package reorder_buffer_pkg;

   localparam int ROB_TAG_W_DEF = 4;
   localparam int ROB_SIZE      = (1 << ROB_TAG_W_DEF) - 1;
   localparam int REG_W         = 5;
   localparam int DATA_W        = 32;

   typedef logic [ROB_TAG_W_DEF-1:0] rob_t;
   typedef logic [REG_W-1:0]         reg_t;
   typedef logic [DATA_W-1:0]        data_t;

   localparam rob_t  ROB_RESET  = '0;
   localparam reg_t  REG_RESET  = '0;
   localparam data_t DATA_RESET = '0;

   typedef enum logic [1:0] {
      ROB_KIND_NORMAL = 2'd0,
      ROB_KIND_BRANCH = 2'd1,
      ROB_KIND_STORE  = 2'd2
   } rob_kind_e;

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup into the reorder buffer with CDB bypass.
// Ports:
//   q_tag_i     producer tag being asked about (0 = no producer)
//   busy_i      per-slot busy flags
//   ready_i     per-slot result-ready flags
//   value_i     per-slot results
//   wb_valid_i  CDB broadcast this cycle (already qualified by the caller)
//   wb_tag_i    CDB tag
//   wb_value_i  CDB result
//   ready_o     producer value is available now
//   value_o     that value (0 when not available or tag 0)
module reorder_buffer_query_port
   import reorder_buffer_pkg::*;
#(
   parameter int TAG_W = ROB_TAG_W_DEF
)
(
   input  logic [TAG_W-1:0]      q_tag_i,
   input  logic [(1<<TAG_W)-1:0] busy_i,
   input  logic [(1<<TAG_W)-1:0] ready_i,
   input  data_t                 value_i [1<<TAG_W],
   input  logic                  wb_valid_i,
   input  logic [TAG_W-1:0]      wb_tag_i,
   input  data_t                 wb_value_i,
   output logic                  ready_o,
   output data_t                 value_o
);

   always_comb begin
      ready_o = 1'b0;
      value_o = DATA_RESET;
      if (q_tag_i == '0) begin
         ready_o = 1'b1;
      end else if (busy_i[q_tag_i] && ready_i[q_tag_i]) begin
         ready_o = 1'b1;
         value_o = value_i[q_tag_i];
      end else if (wb_valid_i && (wb_tag_i == q_tag_i)) begin
         // result is on the CDB right now; forward it instead of waiting a cycle
         ready_o = 1'b1;
         value_o = wb_value_i;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, collects CDB results,
// and retires one instruction per cycle in program order from the head.
// A retiring mispredicted branch flushes every slot and redirects the PC.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = hold all state)
//   alloc_*          dispatcher allocation at alloc_tag_out; full_out when 15 live
//   q1_*/q2_*        operand producer lookup with CDB bypass (combinational)
//   wb_*             CDB writeback: value, mispredict flag, corrected target
//   commit_*         registered commit pulse with rd/value/tag of the retired slot
//   store_commit_out head store retired
//   rollback_*       registered flush pulse and redirect PC
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_TAG_W = ROB_TAG_W_DEF
)
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 alloc_valid_in,
   input  reg_t                 alloc_rd_in,
   input  logic [1:0]           alloc_kind_in,
   output logic [ROB_TAG_W-1:0] alloc_tag_out,
   output logic                 full_out,
   input  logic [ROB_TAG_W-1:0] q1_tag_in,
   input  logic [ROB_TAG_W-1:0] q2_tag_in,
   output logic                 q1_ready_out,
   output logic                 q2_ready_out,
   output data_t                q1_value_out,
   output data_t                q2_value_out,
   input  logic                 wb_valid_in,
   input  logic [ROB_TAG_W-1:0] wb_tag_in,
   input  data_t                wb_value_in,
   input  logic                 wb_mispredict_in,
   input  logic [31:0]          wb_target_in,
   output logic                 commit_flag_out,
   output reg_t                 commit_rd_out,
   output data_t                commit_value_out,
   output logic [ROB_TAG_W-1:0] commit_tag_out,
   output logic                 store_commit_out,
   output logic                 rollback_flag_out,
   output logic [31:0]          rollback_pc_out
);

   localparam int NSLOT      = 1 << ROB_TAG_W;
   localparam int ROB_SIZE_L = NSLOT - 1;

   typedef logic [ROB_TAG_W-1:0] tag_t;

   localparam tag_t TAG_ONE = tag_t'(1);
   localparam tag_t TAG_MAX = tag_t'(ROB_SIZE_L);

   // tag 0 is never a slot, so the pointers wrap from the last slot back to 1
   function automatic tag_t next_tag(input tag_t t);
      return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
   endfunction

   logic [NSLOT-1:0] busy_q, busy_d;
   logic [NSLOT-1:0] ready_q, ready_d;
   logic [NSLOT-1:0] misp_q, misp_d;
   reg_t             rd_q     [NSLOT];
   reg_t             rd_d     [NSLOT];
   rob_kind_e        kind_q   [NSLOT];
   rob_kind_e        kind_d   [NSLOT];
   data_t            value_q  [NSLOT];
   data_t            value_d  [NSLOT];
   logic [31:0]      target_q [NSLOT];
   logic [31:0]      target_d [NSLOT];

   tag_t head_q, head_d;
   tag_t tail_q, tail_d;
   tag_t count_q, count_d;

   logic        commit_flag_q, commit_flag_d;
   reg_t        commit_rd_q, commit_rd_d;
   data_t       commit_value_q, commit_value_d;
   tag_t        commit_tag_q, commit_tag_d;
   logic        store_commit_q, store_commit_d;
   logic        rollback_flag_q, rollback_flag_d;
   logic [31:0] rollback_pc_q, rollback_pc_d;

   logic full;
   logic wb_live;
   logic do_commit;
   logic do_flush;
   logic do_wb;
   logic do_alloc;

   assign full = (count_q == TAG_MAX);

   // While the flush pulse is out, incoming alloc/wb belong to squashed work.
   assign wb_live   = wb_valid_in & ~rollback_flag_q;
   assign do_commit = busy_q[head_q] & ready_q[head_q];
   assign do_flush  = do_commit & misp_q[head_q];
   assign do_wb     = wb_live & (wb_tag_in != '0) & busy_q[wb_tag_in] & ~do_flush;
   assign do_alloc  = alloc_valid_in & ~full & ~rollback_flag_q & ~do_flush;

   always_comb begin
      busy_d          = busy_q;
      ready_d         = ready_q;
      misp_d          = misp_q;
      rd_d            = rd_q;
      kind_d          = kind_q;
      value_d         = value_q;
      target_d        = target_q;
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      commit_flag_d   = 1'b0;
      store_commit_d  = 1'b0;
      rollback_flag_d = 1'b0;
      commit_rd_d     = commit_rd_q;
      commit_value_d  = commit_value_q;
      commit_tag_d    = commit_tag_q;
      rollback_pc_d   = rollback_pc_q;

      if (rdy_in) begin
         if (do_wb) begin
            ready_d[wb_tag_in]  = 1'b1;
            value_d[wb_tag_in]  = wb_value_in;
            misp_d[wb_tag_in]   = wb_mispredict_in;
            target_d[wb_tag_in] = wb_target_in;
         end

         if (do_alloc) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            misp_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = alloc_rd_in;
            kind_d[tail_q]  = rob_kind_e'(alloc_kind_in);
            tail_d          = next_tag(tail_q);
         end

         // commit decision uses pre-edge ready, so it overrides a same-cycle wb to head
         if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = next_tag(head_q);
            commit_flag_d   = 1'b1;
            commit_rd_d     = rd_q[head_q];
            commit_value_d  = value_q[head_q];
            commit_tag_d    = head_q;
            store_commit_d  = (kind_q[head_q] == ROB_KIND_STORE);
         end

         case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + TAG_ONE;
            2'b01:   count_d = count_q - TAG_ONE;
            default: count_d = count_q;
         endcase

         if (do_flush) begin
            busy_d          = '0;
            ready_d         = '0;
            misp_d          = '0;
            head_d          = TAG_ONE;
            tail_d          = TAG_ONE;
            count_d         = '0;
            rollback_flag_d = 1'b1;
            rollback_pc_d   = target_q[head_q];
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q  <= '0;
         ready_q <= '0;
         misp_q  <= '0;
         for (int i = 0; i < NSLOT; i++) begin
            rd_q[i]     <= REG_RESET;
            kind_q[i]   <= ROB_KIND_NORMAL;
            value_q[i]  <= DATA_RESET;
            target_q[i] <= '0;
         end
         head_q          <= TAG_ONE;
         tail_q          <= TAG_ONE;
         count_q         <= '0;
         commit_flag_q   <= 1'b0;
         commit_rd_q     <= REG_RESET;
         commit_value_q  <= DATA_RESET;
         commit_tag_q    <= '0;
         store_commit_q  <= 1'b0;
         rollback_flag_q <= 1'b0;
         rollback_pc_q   <= '0;
      end else begin
         busy_q          <= busy_d;
         ready_q         <= ready_d;
         misp_q          <= misp_d;
         rd_q            <= rd_d;
         kind_q          <= kind_d;
         value_q         <= value_d;
         target_q        <= target_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         commit_flag_q   <= commit_flag_d;
         commit_rd_q     <= commit_rd_d;
         commit_value_q  <= commit_value_d;
         commit_tag_q    <= commit_tag_d;
         store_commit_q  <= store_commit_d;
         rollback_flag_q <= rollback_flag_d;
         rollback_pc_q   <= rollback_pc_d;
      end
   end

   reorder_buffer_query_port #(.TAG_W(ROB_TAG_W)) u_rob_query_port_q1 (
      .q_tag_i    (q1_tag_in),
      .busy_i     (busy_q),
      .ready_i    (ready_q),
      .value_i    (value_q),
      .wb_valid_i (wb_live),
      .wb_tag_i   (wb_tag_in),
      .wb_value_i (wb_value_in),
      .ready_o    (q1_ready_out),
      .value_o    (q1_value_out)
   );

   reorder_buffer_query_port #(.TAG_W(ROB_TAG_W)) u_rob_query_port_q2 (
      .q_tag_i    (q2_tag_in),
      .busy_i     (busy_q),
      .ready_i    (ready_q),
      .value_i    (value_q),
      .wb_valid_i (wb_live),
      .wb_tag_i   (wb_tag_in),
      .wb_value_i (wb_value_in),
      .ready_o    (q2_ready_out),
      .value_o    (q2_value_out)
   );

   assign alloc_tag_out     = tail_q;
   assign full_out          = full;
   assign commit_flag_out   = commit_flag_q;
   assign commit_rd_out     = commit_rd_q;
   assign commit_value_out  = commit_value_q;
   assign commit_tag_out    = commit_tag_q;
   assign store_commit_out  = store_commit_q;
   assign rollback_flag_out = rollback_flag_q;
   assign rollback_pc_out   = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        alloc_valid = 1'b0;
   reg_t        alloc_rd = '0;
   logic [1:0]  alloc_kind = 2'd0;
   logic [3:0]  alloc_tag;
   logic        full;
   logic [3:0]  q1_tag = 4'd1;
   logic [3:0]  q2_tag = 4'd1;
   logic        q1_ready, q2_ready;
   data_t       q1_value, q2_value;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_tag = '0;
   data_t       wb_value = '0;
   logic        wb_misp = 1'b0;
   logic [31:0] wb_target = '0;
   logic        commit_flag;
   reg_t        commit_rd;
   data_t       commit_value;
   logic [3:0]  commit_tag;
   logic        store_commit;
   logic        rollback_flag;
   logic [31:0] rollback_pc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  tag;
      logic        st;
      logic        rb;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   reorder_buffer dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .rdy_in            (rdy),
      .alloc_valid_in    (alloc_valid),
      .alloc_rd_in       (alloc_rd),
      .alloc_kind_in     (alloc_kind),
      .alloc_tag_out     (alloc_tag),
      .full_out          (full),
      .q1_tag_in         (q1_tag),
      .q2_tag_in         (q2_tag),
      .q1_ready_out      (q1_ready),
      .q2_ready_out      (q2_ready),
      .q1_value_out      (q1_value),
      .q2_value_out      (q2_value),
      .wb_valid_in       (wb_valid),
      .wb_tag_in         (wb_tag),
      .wb_value_in       (wb_value),
      .wb_mispredict_in  (wb_misp),
      .wb_target_in      (wb_target),
      .commit_flag_out   (commit_flag),
      .commit_rd_out     (commit_rd),
      .commit_value_out  (commit_value),
      .commit_tag_out    (commit_tag),
      .store_commit_out  (store_commit),
      .rollback_flag_out (rollback_flag),
      .rollback_pc_out   (rollback_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag,
                       input logic st, input logic rb, input logic [31:0] pc);
      exp_t e;
      e.rd = rd; e.val = val; e.tag = tag; e.st = st; e.rb = rb; e.pc = pc;
      sb.push_back(e);
   endtask

   // Monitor: every commit pulse is matched against the oldest expected retirement.
   always @(negedge clk) begin
      if (!rst) begin
         if (commit_flag) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit_tag", {28'd0, commit_tag}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("commit_tag", {28'd0, commit_tag}, {28'd0, e.tag});
               chk("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
               chk("commit_value", commit_value, e.val);
               chk("store_commit", {31'd0, store_commit}, {31'd0, e.st});
               chk("rollback_flag", {31'd0, rollback_flag}, {31'd0, e.rb});
               if (e.rb) chk("rollback_pc", rollback_pc, e.pc);
            end
         end else begin
            if (rollback_flag) chk("rollback_without_commit", 32'd1, 32'd0);
            if (store_commit)  chk("store_without_commit", 32'd1, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
      wb_misp     = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [1:0] kind);
      alloc_valid = 1'b1; alloc_rd = rd; alloc_kind = kind;
   endtask

   task automatic wb(input logic [3:0] tag, input logic [31:0] val, input logic misp,
                     input logic [31:0] tgt);
      wb_valid = 1'b1; wb_tag = tag; wb_value = val; wb_misp = misp; wb_target = tgt;
   endtask

   initial begin
      // reset without any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_commit_flag", {31'd0, commit_flag}, 32'd0);
      chk("rst_rollback_flag", {31'd0, rollback_flag}, 32'd0);
      chk("rst_store_commit", {31'd0, store_commit}, 32'd0);
      chk("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
      chk("rst_commit_value", commit_value, 32'd0);
      chk("rst_commit_tag", {28'd0, commit_tag}, 32'd0);
      chk("rst_rollback_pc", rollback_pc, 32'd0);
      chk("rst_alloc_tag", {28'd0, alloc_tag}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_q1_ready", {31'd0, q1_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // basic commit and writeback latency
      alloc(5'd5, 2'd0);
      step(); clr();
      chk("basic_alloc_tag", {28'd0, alloc_tag}, 32'd2);
      push(5'd5, 32'h1234, 4'd1, 1'b0, 1'b0, 32'd0);
      wb(4'd1, 32'h1234, 1'b0, 32'd0);
      step(); clr();
      chk("basic_flag_after_E", {31'd0, commit_flag}, 32'd0);
      step();
      chk("basic_flag_after_E1", {31'd0, commit_flag}, 32'd1);
      step();
      chk("basic_flag_drops", {31'd0, commit_flag}, 32'd0);

      // out-of-order writeback, in-order retire, tag 3 is a store
      do_reset();
      alloc(5'd1, 2'd0); step();
      alloc(5'd2, 2'd0); step();
      alloc(5'd3, 2'd2); step(); clr();
      push(5'd1, 32'h11, 4'd1, 1'b0, 1'b0, 32'd0);
      push(5'd2, 32'h22, 4'd2, 1'b0, 1'b0, 32'd0);
      push(5'd3, 32'h33, 4'd3, 1'b1, 1'b0, 32'd0);
      wb(4'd3, 32'h33, 1'b0, 32'd0); step();
      wb(4'd2, 32'h22, 1'b0, 32'd0); step();
      chk("ooo_no_early_commit", {31'd0, commit_flag}, 32'd0);
      wb(4'd1, 32'h11, 1'b0, 32'd0); step(); clr();
      chk("ooo_flag_E", {31'd0, commit_flag}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ooo_back_to_back", {31'd0, commit_flag}, 32'd1);
      end
      step();
      chk("ooo_flag_end", {31'd0, commit_flag}, 32'd0);

      // full, ignored 16th alloc, tag reuse and tail wrap
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         alloc(5'(i), 2'd0);
         step();
      end
      clr();
      chk("full_set", {31'd0, full}, 32'd1);
      chk("full_tail_wrap", {28'd0, alloc_tag}, 32'd1);
      alloc(5'd31, 2'd0); step(); clr();
      chk("full_ignored_full", {31'd0, full}, 32'd1);
      chk("full_ignored_tag", {28'd0, alloc_tag}, 32'd1);
      push(5'd1, 32'hA1, 4'd1, 1'b0, 1'b0, 32'd0);
      wb(4'd1, 32'hA1, 1'b0, 32'd0); step(); clr();
      step();
      chk("full_after_commit", {31'd0, full}, 32'd0);
      chk("reuse_tag", {28'd0, alloc_tag}, 32'd1);
      alloc(5'd20, 2'd0); step(); clr();
      chk("reuse_next_tag", {28'd0, alloc_tag}, 32'd2);
      chk("reuse_full", {31'd0, full}, 32'd1);
      for (int t = 2; t <= 15; t++) begin
         push(5'(t), 32'h100 + t, 4'(t), 1'b0, 1'b0, 32'd0);
         wb(4'(t), 32'h100 + t, 1'b0, 32'd0);
         step();
      end
      push(5'd20, 32'hB1, 4'd1, 1'b0, 1'b0, 32'd0);
      wb(4'd1, 32'hB1, 1'b0, 32'd0); step(); clr();
      for (int i = 0; i < 4; i++) step();
      chk("drain_empty_not_full", {31'd0, full}, 32'd0);
      chk("drain_sb_empty", sb.size(), 32'd0);

      // mispredict flush
      do_reset();
      alloc(5'd1, 2'd0); step();
      alloc(5'd0, 2'd1); step();
      alloc(5'd3, 2'd0); step();
      alloc(5'd4, 2'd0); step(); clr();
      push(5'd1, 32'h11, 4'd1, 1'b0, 1'b0, 32'd0);
      push(5'd0, 32'h0, 4'd2, 1'b0, 1'b1, 32'h100);
      wb(4'd2, 32'h0, 1'b1, 32'h100); step();
      wb(4'd1, 32'h11, 1'b0, 32'd0); step(); clr();
      step();
      chk("misp_commit1_no_rb", {31'd0, rollback_flag}, 32'd0);
      step();
      chk("misp_rb_flag", {31'd0, rollback_flag}, 32'd1);
      chk("misp_rb_pc", rollback_pc, 32'h100);
      chk("misp_tail_reset", {28'd0, alloc_tag}, 32'd1);
      chk("misp_not_full", {31'd0, full}, 32'd0);
      alloc(5'd7, 2'd0);
      wb(4'd3, 32'h33, 1'b0, 32'd0);
      step(); clr();
      chk("misp_alloc_dropped", {28'd0, alloc_tag}, 32'd1);
      chk("misp_rb_pulse_ends", {31'd0, rollback_flag}, 32'd0);
      wb(4'd3, 32'h33, 1'b0, 32'd0); step(); clr();
      for (int i = 0; i < 3; i++) step();
      alloc(5'd9, 2'd0); step(); clr();
      chk("post_flush_alloc_tag", {28'd0, alloc_tag}, 32'd2);
      // rdy low: wb is held off, nothing retires
      rdy = 1'b0;
      wb(4'd1, 32'h99, 1'b0, 32'd0); step(); step();
      rdy = 1'b1; clr();
      step(); step();
      chk("rdy_low_no_commit", {31'd0, commit_flag}, 32'd0);
      push(5'd9, 32'h99, 4'd1, 1'b0, 1'b0, 32'd0);
      wb(4'd1, 32'h99, 1'b0, 32'd0); step(); clr();
      step(); step();

      // query bypass
      do_reset();
      alloc(5'd10, 2'd0); step();
      alloc(5'd11, 2'd0); step(); clr();
      q1_tag = 4'd2; q2_tag = 4'd0;
      #1;
      chk("q1_not_ready", {31'd0, q1_ready}, 32'd0);
      wb(4'd2, 32'hBEEF, 1'b0, 32'd0);
      #1;
      chk("q1_bypass_ready", {31'd0, q1_ready}, 32'd1);
      chk("q1_bypass_value", q1_value, 32'hBEEF);
      chk("q2_tag0_ready", {31'd0, q2_ready}, 32'd1);
      chk("q2_tag0_value", q2_value, 32'd0);
      step(); clr();
      chk("q1_slot_ready", {31'd0, q1_ready}, 32'd1);
      chk("q1_slot_value", q1_value, 32'hBEEF);
      push(5'd10, 32'h10, 4'd1, 1'b0, 1'b0, 32'd0);
      push(5'd11, 32'hBEEF, 4'd2, 1'b0, 1'b0, 32'd0);
      wb(4'd1, 32'h10, 1'b0, 32'd0); step(); clr();
      for (int i = 0; i < 4; i++) step();

      chk("final_sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
